// File: rtl/splash_pkg.sv
// Shared encodings for the splash screen sequencer: stage codes, ROM selects,
// counter widths and the image address helper.
package splash_pkg;

  typedef enum logic [1:0] {
    STAGE_TITLE  = 2'd0,
    STAGE_SLIDE  = 2'd1,
    STAGE_REVEAL = 2'd2,
    STAGE_HOLD   = 2'd3
  } stageT;

  typedef enum logic [1:0] {
    ROM_TITLE      = 2'd0,
    ROM_SLIDE      = 2'd1,
    ROM_BACKGROUND = 2'd2
  } romSelT;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;

  localparam int ADDR_W  = 17;
  localparam int GTICK_W = 11;
  localparam int STICK_W = 11;

  // Images are stored column-major with rows flipped, so the address is the
  // flipped row plus one full column height per column offset.
  function automatic logic [ADDR_W-1:0] imageAddr(
    input logic [ADDR_W-1:0] flippedRow,
    input logic [ADDR_W-1:0] column,
    input logic [ADDR_W-1:0] columnHeight
  );
    return flippedRow + columnHeight * column;
  endfunction

endpackage

// File: rtl/splash_sequencer_if.sv
// LCD pixel / image ROM bundle between the display side and the sequencer.
interface splash_sequencer_if;

  logic [9:0]  xAddLCD;
  logic [8:0]  yAddLCD;
  logic [16:0] romAddr;
  logic [1:0]  romSel;
  logic [15:0] romData;
  logic [15:0] pixelData;

  modport master (
    output xAddLCD, yAddLCD, romData,
    input  romAddr, romSel, pixelData
  );

  modport slave (
    input  xAddLCD, yAddLCD, romData,
    output romAddr, romSel, pixelData
  );

endinterface

// File: rtl/splash_timebase.sv
// Animation timebase: tick prescaler, per-stage tick counter, saturating
// global tick counter and the one-shot audio trigger.
module splash_timebase
  import splash_pkg::*;
#(
  parameter int TICK_DIV  = 5000000,
  parameter int T_TITLE   = 20,
  parameter int T_SLIDE   = 60,
  parameter int T_REVEAL  = 16,
  parameter int TRIG_TICK = 20
) (
  input  logic               clock,
  input  logic               globalReset,
  input  logic               skip,
  input  stageT              stage,
  output logic               advance,
  output logic [STICK_W-1:0] stick,
  output logic               triggerImperialMarch
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [GTICK_W:0]   TRIG_AT    = (GTICK_W + 1)'(TRIG_TICK);

  logic [PRESC_W-1:0] prescaler;
  logic [GTICK_W-1:0] gtick;
  logic [STICK_W-1:0] stickLast;
  logic               tick;
  logic               skipTaken;
  logic               stageEnd;
  logic               fireNow;
  logic               triggerFired;
  logic               titleSkipped;

  assign tick = (prescaler == PRESC_LAST);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves stickLast unassigned (no latch).
    stickLast = '0;
    case (stage)
      STAGE_TITLE:  stickLast = STICK_W'(T_TITLE - 1);
      STAGE_SLIDE:  stickLast = STICK_W'(T_SLIDE - 1);
      STAGE_REVEAL: stickLast = STICK_W'(T_REVEAL - 1);
      default:      stickLast = '0;
    endcase
  end

  // HOLD is terminal, so neither skip nor the stage timer can move it.
  assign skipTaken = skip && (stage != STAGE_HOLD);
  assign stageEnd  = tick && (stage != STAGE_HOLD) && (stick == stickLast);
  assign advance   = skipTaken || stageEnd;

  assign fireNow = tick && !triggerFired && !titleSkipped &&
                   (({1'b0, gtick} + (GTICK_W + 1)'(1)) == TRIG_AT);

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments keep every register update on the same edge, independent of order.
    if (globalReset) begin
      prescaler            <= '0;
      stick                <= '0;
      gtick                <= '0;
      triggerFired         <= 1'b0;
      titleSkipped         <= 1'b0;
      triggerImperialMarch <= 1'b0;
    end else begin
      prescaler <= (tick || skipTaken) ? '0 : prescaler + PRESC_W'(1);

      if (advance) begin
        stick <= '0;
      end else if (tick && (stick != '1)) begin
        stick <= stick + STICK_W'(1);
      end

      if (tick && (gtick != '1)) begin
        gtick <= gtick + GTICK_W'(1);
      end

      if (skipTaken && (stage == STAGE_TITLE)) begin
        titleSkipped <= 1'b1;
      end

      triggerImperialMarch <= fireNow;
      if (fireNow) begin
        triggerFired <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/splash_sequencer.sv
// Splash screen sequencer: TITLE -> SLIDE -> REVEAL -> HOLD stage machine,
// per-stage window/ROM address generation and a two-clock pixel pipeline.
module splash_sequencer
  import splash_pkg::*;
#(
  parameter int TICK_DIV    = 5000000,
  parameter int LCD_W       = 240,
  parameter int LCD_H       = 320,
  parameter int T_TITLE     = 20,
  parameter int T_SLIDE     = 60,
  parameter int T_REVEAL    = 16,
  parameter int SLIDE_STEP  = 4,
  parameter int REVEAL_STEP = 10,
  parameter int TRIG_TICK   = 20,
  parameter int TITLE_X0    = 90,
  parameter int TITLE_W     = 60,
  parameter int TITLE_Y0    = 20,
  parameter int TITLE_H     = 280,
  parameter int SLIDE_W     = 32,
  parameter int SLIDE_Y0    = 51,
  parameter int SLIDE_H     = 217
) (
  input  logic               clock,
  input  logic               globalReset,
  input  logic               skip,
  splash_sequencer_if.slave  lcd,
  output logic               triggerImperialMarch,
  output logic [1:0]         stage,
  output logic               done
);

  localparam logic [ADDR_W-1:0] TITLE_X_LO   = ADDR_W'(TITLE_X0);
  localparam logic [ADDR_W-1:0] TITLE_X_HI   = ADDR_W'(TITLE_X0 + TITLE_W - 1);
  localparam logic [ADDR_W-1:0] TITLE_Y_LO   = ADDR_W'(TITLE_Y0);
  localparam logic [ADDR_W-1:0] TITLE_Y_HI   = ADDR_W'(TITLE_Y0 + TITLE_H - 1);
  localparam logic [ADDR_W-1:0] TITLE_ROWS   = ADDR_W'(TITLE_H);
  localparam logic [ADDR_W-1:0] SLIDE_SPAN   = ADDR_W'(SLIDE_W - 1);
  localparam logic [ADDR_W-1:0] SLIDE_Y_LO   = ADDR_W'(SLIDE_Y0);
  localparam logic [ADDR_W-1:0] SLIDE_Y_HI   = ADDR_W'(SLIDE_Y0 + SLIDE_H - 1);
  localparam logic [ADDR_W-1:0] SLIDE_ROWS   = ADDR_W'(SLIDE_H);
  localparam logic [ADDR_W-1:0] LCD_ROWS     = ADDR_W'(LCD_H);
  localparam logic [ADDR_W-1:0] LCD_ROW_LAST = ADDR_W'(LCD_H - 1);
  localparam logic [ADDR_W-1:0] HALF_H       = ADDR_W'(LCD_H / 2);

  stageT              state;
  stageT              nextState;
  logic               advance;
  logic [STICK_W-1:0] stick;

  logic [ADDR_W-1:0]  xPos;
  logic [ADDR_W-1:0]  yPos;
  logic [31:0]        slideTravel;
  logic [31:0]        revealGrow;
  logic [ADDR_W-1:0]  slideLeft;
  logic [ADDR_W-1:0]  revealHalf;
  logic [ADDR_W-1:0]  addrNext;
  romSelT             selNext;
  logic               inWindow;
  logic               inWindowQ;

  splash_timebase #(
    .TICK_DIV  (TICK_DIV),
    .T_TITLE   (T_TITLE),
    .T_SLIDE   (T_SLIDE),
    .T_REVEAL  (T_REVEAL),
    .TRIG_TICK (TRIG_TICK)
  ) timebase (
    .clock                (clock),
    .globalReset          (globalReset),
    .skip                 (skip),
    .stage                (state),
    .advance              (advance),
    .stick                (stick),
    .triggerImperialMarch (triggerImperialMarch)
  );

  always_ff @(posedge clock) begin
    if (globalReset) begin
      state <= STAGE_TITLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    if (advance) begin
      case (state)
        STAGE_TITLE:  nextState = STAGE_SLIDE;
        STAGE_SLIDE:  nextState = STAGE_REVEAL;
        STAGE_REVEAL: nextState = STAGE_HOLD;
        default:      nextState = STAGE_HOLD;
      endcase
    end
  end

  always_comb begin
    stage = state;
    done  = (state == STAGE_HOLD);
  end

  assign xPos = {7'd0, lcd.xAddLCD};
  assign yPos = {8'd0, lcd.yAddLCD};

  // Slide left edge and reveal half-height saturate instead of wrapping.
  assign slideTravel = 32'(stick) * 32'(SLIDE_STEP);
  assign revealGrow  = 32'(stick) * 32'(REVEAL_STEP);
  assign slideLeft   = (slideTravel >= 32'(LCD_W)) ? '0
                                                   : ADDR_W'(32'(LCD_W) - slideTravel);
  assign revealHalf  = (revealGrow >= 32'(LCD_H / 2)) ? HALF_H : ADDR_W'(revealGrow);

  always_comb begin
    inWindow = 1'b0;
    addrNext = '0;
    selNext  = ROM_TITLE;
    case (state)
      STAGE_TITLE: begin
        selNext  = ROM_TITLE;
        inWindow = (xPos >= TITLE_X_LO) && (xPos <= TITLE_X_HI) &&
                   (yPos >= TITLE_Y_LO) && (yPos <= TITLE_Y_HI);
        if (inWindow) addrNext = imageAddr(TITLE_Y_HI - yPos, xPos - TITLE_X_LO, TITLE_ROWS);
      end
      STAGE_SLIDE: begin
        selNext  = ROM_SLIDE;
        inWindow = (xPos >= slideLeft) && (xPos <= slideLeft + SLIDE_SPAN) &&
                   (yPos >= SLIDE_Y_LO) && (yPos <= SLIDE_Y_HI);
        if (inWindow) addrNext = imageAddr(SLIDE_Y_HI - yPos, xPos - slideLeft, SLIDE_ROWS);
      end
      STAGE_REVEAL: begin
        selNext  = ROM_BACKGROUND;
        inWindow = (yPos >= HALF_H - revealHalf) && (yPos < HALF_H + revealHalf);
        if (inWindow) addrNext = imageAddr(LCD_ROW_LAST - yPos, xPos, LCD_ROWS);
      end
      default: begin
        selNext  = ROM_BACKGROUND;
        inWindow = 1'b1;
        addrNext = imageAddr(LCD_ROW_LAST - yPos, xPos, LCD_ROWS);
      end
    endcase
  end

  // The window flag travels with the address so a mid-line stage change
  // never pairs one stage's window with another stage's ROM data.
  always_ff @(posedge clock) begin
    if (globalReset) begin
      lcd.romAddr   <= '0;
      lcd.romSel    <= ROM_TITLE;
      inWindowQ     <= 1'b0;
      lcd.pixelData <= RGB565_BLACK;
    end else begin
      lcd.romAddr   <= addrNext;
      lcd.romSel    <= selNext;
      inWindowQ     <= inWindow;
      lcd.pixelData <= inWindowQ ? lcd.romData : RGB565_BLACK;
    end
  end

endmodule

// File: tb/tb_splash_sequencer.sv
// Directed bench for splash_sequencer with a pixel scoreboard and a behavioural ROM.
`timescale 1ns/1ps
module tb_splash_sequencer;

  typedef struct {
    int          due;
    logic [15:0] pix;
    string       tag;
  } sbEntryT;

  logic       clock = 1'b0;
  logic       globalReset;
  logic       skip;
  logic       trig;
  logic [1:0] stage;
  logic       done;

  int errors    = 0;
  int checks    = 0;
  int cyc       = 0;
  int relCyc    = 0;
  int trigCount = 0;
  int trigAt    = -1;
  sbEntryT sb[$];

  splash_sequencer_if lcd();

  splash_sequencer #(
    .TICK_DIV   (4),
    .T_TITLE    (3),
    .T_SLIDE    (5),
    .T_REVEAL   (2),
    .TRIG_TICK  (2),
    .SLIDE_STEP (80)
  ) dut (
    .clock                (clock),
    .globalReset          (globalReset),
    .skip                 (skip),
    .lcd                  (lcd),
    .triggerImperialMarch (trig),
    .stage                (stage),
    .done                 (done)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] romModel(input logic [1:0] sel, input logic [16:0] addr);
    return {sel, addr[13:0]} ^ 16'hA5C3;
  endfunction

  always_comb lcd.romData = romModel(lcd.romSel, lcd.romAddr);

  always @(posedge clock) begin
    cyc    <= cyc + 1;
    relCyc <= globalReset ? 0 : relCyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    sbEntryT entry;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      entry = sb.pop_front();
      check(entry.tag, {16'd0, lcd.pixelData}, {16'd0, entry.pix});
    end
  end

  always @(negedge clock) begin
    if (trig === 1'b1) begin
      trigCount <= trigCount + 1;
      trigAt    <= relCyc;
    end
  end

  task automatic drivePixel(input int x, input int y, input logic [15:0] expPix, input string tag);
    lcd.xAddLCD = 10'(x);
    lcd.yAddLCD = 9'(y);
    sb.push_back('{cyc + 2, expPix, tag});
  endtask

  task automatic gotoRel(input int n);
    int guard = 0;
    while (relCyc != n && guard < 5000) begin
      @(posedge clock);
      #1;
      guard++;
    end
    if (relCyc != n) begin
      checks++;
      errors++;
      $error("FAIL goto_rel: observed %0d expected %0d", relCyc, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int trigBase;
    globalReset = 1'b1;
    skip        = 1'b0;
    lcd.xAddLCD = '0;
    lcd.yAddLCD = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_stage",   32'(stage), 32'd0);
    check("rst_done",    32'(done), 32'd0);
    check("rst_trig",    32'(trig), 32'd0);
    check("rst_pixel",   32'(lcd.pixelData), 32'd0);
    check("rst_romaddr", 32'(lcd.romAddr), 32'd0);
    check("rst_romsel",  32'(lcd.romSel), 32'd0);
    globalReset = 1'b0;

    // Run 1: free run through every stage
    drivePixel(149, 20, romModel(2'd0, 17'd16799), "title_corner");
    gotoRel(1);
    check("title_corner_addr", 32'(lcd.romAddr), 32'd16799);
    check("title_corner_sel",  32'(lcd.romSel), 32'd0);
    drivePixel(90, 299, romModel(2'd0, 17'd0), "title_origin");
    gotoRel(2);
    check("title_origin_addr", 32'(lcd.romAddr), 32'd0);
    drivePixel(89, 299, 16'h0000, "title_left_of_window");
    gotoRel(3);
    drivePixel(90, 19, 16'h0000, "title_above_window");
    gotoRel(4);
    lcd.xAddLCD = '0;
    lcd.yAddLCD = '0;
    gotoRel(11);
    check("stage_title_last", 32'(stage), 32'd0);
    gotoRel(12);
    check("stage_slide_entry", 32'(stage), 32'd1);
    gotoRel(16);
    drivePixel(160, 267, romModel(2'd1, 17'd0), "slide_stick1_edge");
    gotoRel(17);
    drivePixel(159, 267, 16'h0000, "slide_stick1_left");
    gotoRel(28);
    drivePixel(0, 51, romModel(2'd1, 17'd216), "slide_saturated");
    gotoRel(29);
    check("slide_saturated_addr", 32'(lcd.romAddr), 32'd216);
    check("slide_saturated_sel",  32'(lcd.romSel), 32'd1);
    drivePixel(32, 51, 16'h0000, "slide_right_of_window");
    gotoRel(31);
    check("stage_slide_last", 32'(stage), 32'd1);
    gotoRel(32);
    check("stage_reveal_entry", 32'(stage), 32'd2);
    drivePixel(5, 159, 16'h0000, "reveal_empty_band");
    gotoRel(36);
    drivePixel(5, 150, romModel(2'd2, 17'd1769), "reveal_band_top");
    gotoRel(37);
    drivePixel(5, 170, 16'h0000, "reveal_below_band");
    gotoRel(39);
    check("stage_reveal_last", 32'(stage), 32'd2);
    check("done_before_hold",  32'(done), 32'd0);
    gotoRel(40);
    check("stage_hold_entry", 32'(stage), 32'd3);
    check("done_in_hold",     32'(done), 32'd1);
    check("trig_count_run1",  32'(trigCount), 32'd1);
    check("trig_at_gtick2",   32'(trigAt), 32'd8);
    drivePixel(0, 0, romModel(2'd2, 17'd319), "hold_background");
    gotoRel(440);
    check("trig_once_after_100_ticks", 32'(trigCount), 32'd1);
    check("stage_hold_terminal",       32'(stage), 32'd3);

    // Run 2: one-clock reset while in REVEAL
    globalReset = 1'b1;
    @(posedge clock);
    #1;
    globalReset = 1'b0;
    gotoRel(36);
    check("stage_reveal_run2", 32'(stage), 32'd2);
    check("trig_count_run2",   32'(trigCount), 32'd2);
    drivePixel(5, 150, romModel(2'd2, 17'd1769), "reveal_before_reset");
    gotoRel(38);
    globalReset = 1'b1;
    @(posedge clock);
    #1;
    check("midreset_stage", 32'(stage), 32'd0);
    check("midreset_pixel", 32'(lcd.pixelData), 32'd0);
    check("midreset_done",  32'(done), 32'd0);
    globalReset = 1'b0;
    gotoRel(1);
    check("after_reset_stage", 32'(stage), 32'd0);
    check("after_reset_pixel", 32'(lcd.pixelData), 32'd0);
    gotoRel(9);
    check("trig_rearmed",    32'(trigCount), 32'd3);
    check("trig_rearmed_at", 32'(trigAt), 32'd8);

    // Run 3: skip out of TITLE before the trigger tick
    globalReset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    globalReset = 1'b0;
    trigBase = trigCount;
    gotoRel(5);
    check("skip_pre_stage", 32'(stage), 32'd0);
    skip = 1'b1;
    gotoRel(6);
    skip = 1'b0;
    check("skip_to_slide", 32'(stage), 32'd1);
    drivePixel(240, 51, romModel(2'd1, 17'd216), "skip_slide_stick0");
    gotoRel(7);
    check("skip_stick0_addr", 32'(lcd.romAddr), 32'd216);
    check("skip_stick0_sel",  32'(lcd.romSel), 32'd1);
    gotoRel(25);
    check("skip_slide_last", 32'(stage), 32'd1);
    gotoRel(26);
    check("skip_reveal_entry", 32'(stage), 32'd2);
    gotoRel(27);
    skip = 1'b1;
    gotoRel(28);
    skip = 1'b0;
    check("skip_to_hold", 32'(stage), 32'd3);
    check("skip_hold_done", 32'(done), 32'd1);
    gotoRel(29);
    skip = 1'b1;
    gotoRel(30);
    skip = 1'b0;
    gotoRel(31);
    check("skip_in_hold_ignored", 32'(stage), 32'd3);
    gotoRel(120);
    check("skip_suppresses_trig", 32'(trigCount), 32'(trigBase));

    repeat (3) @(posedge clock);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
